// File: rtl/rockband_pkg.sv
// Shared types and constants for the rhythm-game note path.
package rockband_pkg;
    localparam int NUM_LANES   = 8;
    localparam int SCORE_W     = 16;
    localparam int COMBO_MAX   = 255;
    localparam int COMBO_SHIFT = 3;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} note_state_t;
endpackage

// File: rtl/note_scheduler_lane.sv
// One lane of the note grid: row shift register, key edge detector, hit/miss judge.
module note_lane #(
    parameter int NUM_ROWS = 16
) (
    input  logic                Clk,
    input  logic                Reset,
    input  logic                clear,
    input  logic                shift,
    input  logic                din,
    input  logic                key,
    output logic [NUM_ROWS-1:0] rows,
    output logic                hit_c,
    output logic                miss_c
);
    logic [NUM_ROWS-1:0] rows_q, rows_d;
    logic                key_prev_q;
    logic                strike_left;

    // Hits are judged on the pre-shift strike row, so a hit note never also misses.
    always_comb begin
        hit_c       = key & ~key_prev_q & rows_q[NUM_ROWS-1];
        strike_left = rows_q[NUM_ROWS-1] & ~hit_c;
        miss_c      = shift & strike_left;
        rows_d      = rows_q;
        rows_d[NUM_ROWS-1] = strike_left;
        if (clear)
            rows_d = '0;
        else if (shift)
            rows_d = {rows_q[NUM_ROWS-2:0], din};
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            rows_q     <= '0;
            key_prev_q <= 1'b0;
        end else begin
            rows_q     <= rows_d;
            key_prev_q <= key;
        end
    end

    assign rows = rows_q;
endmodule

// File: rtl/note_scheduler.sv
// Song sequencer: FSM, scroll phase, chart intake, score/combo over NUM_LANES note lanes.
module note_scheduler #(
    parameter int NUM_LANES      = rockband_pkg::NUM_LANES,
    parameter int NUM_ROWS       = 16,
    parameter int TICKS_PER_STEP = 8,
    parameter int SCORE_W        = rockband_pkg::SCORE_W
) (
    input  logic                                Clk,
    input  logic                                Reset,
    input  logic                                start,
    input  logic                                frame_tick,
    input  logic [NUM_LANES-1:0]                keyTrack,
    input  logic                                chart_valid,
    input  logic [NUM_LANES-1:0]                chart_data,
    input  logic                                chart_last,
    output logic                                chart_ready,
    output logic [NUM_LANES*NUM_ROWS-1:0]       note_grid,
    output logic [$clog2(TICKS_PER_STEP)-1:0]   scroll_phase,
    output logic [NUM_LANES-1:0]                hit,
    output logic [NUM_LANES-1:0]                miss,
    output logic [SCORE_W-1:0]                  score,
    output logic [7:0]                          combo,
    output logic                                playing,
    output logic                                done
);
    import rockband_pkg::*;

    localparam int PH_W  = $clog2(TICKS_PER_STEP);
    localparam int DR_W  = $clog2(NUM_ROWS + 1);
    localparam int H_W   = $clog2(NUM_LANES + 1);
    localparam int MW    = 8 - COMBO_SHIFT + 1;
    localparam int SUM_W = SCORE_W + H_W + MW;
    localparam int CW    = 8 + H_W;

    note_state_t                          state_q;
    logic                                 playing_q, done_q;
    logic [PH_W-1:0]                      phase_q, phase_d;
    logic [DR_W-1:0]                      drain_q, drain_d;
    logic [SCORE_W-1:0]                   score_q, score_d;
    logic [7:0]                           combo_q, combo_d;
    logic [NUM_LANES-1:0]                 hit_c, miss_c, hit_q, miss_q;
    logic [NUM_LANES-1:0][NUM_ROWS-1:0]   rows;
    logic                                 active, restart, boundary, xfer;
    logic [H_W-1:0]                       h;
    logic [MW-1:0]                        mult;
    logic [SUM_W-1:0]                     sum;
    logic [CW-1:0]                        csum;

    always_comb begin
        active      = (state_q == RUN) || (state_q == DRAIN);
        restart     = start && ((state_q == IDLE) || (state_q == DONE));
        boundary    = frame_tick && active && (phase_q == PH_W'(TICKS_PER_STEP - 1));
        chart_ready = (state_q == RUN) && boundary;
        xfer        = chart_valid && chart_ready;
    end

    for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
        note_lane #(.NUM_ROWS(NUM_ROWS)) u_lane (
            .Clk    (Clk),
            .Reset  (Reset),
            .clear  (restart),
            .shift  (boundary),
            .din    (chart_data[l] & xfer),
            .key    (keyTrack[l]),
            .rows   (rows[l]),
            .hit_c  (hit_c[l]),
            .miss_c (miss_c[l])
        );
    end

    // Scoring uses the pre-update combo; a miss anywhere zeroes combo but points still land.
    always_comb begin
        h = '0;
        for (int l = 0; l < NUM_LANES; l++)
            h = h + H_W'(hit_c[l]);
        mult = MW'(combo_q[7:COMBO_SHIFT]) + MW'(1);
        sum  = SUM_W'(score_q) + SUM_W'(h) * SUM_W'(mult);
        csum = CW'(combo_q) + CW'(h);

        score_d = (|sum[SUM_W-1:SCORE_W]) ? '1 : sum[SCORE_W-1:0];
        if (|miss_c)
            combo_d = '0;
        else if (csum > CW'(COMBO_MAX))
            combo_d = 8'(COMBO_MAX);
        else
            combo_d = csum[7:0];

        phase_d = phase_q;
        if (active && frame_tick)
            phase_d = boundary ? '0 : phase_q + PH_W'(1);
        drain_d = drain_q;
        if ((state_q == DRAIN) && boundary)
            drain_d = drain_q + DR_W'(1);

        if (restart) begin
            score_d = '0;
            combo_d = '0;
            phase_d = '0;
            drain_d = '0;
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q   <= IDLE;
            playing_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            case (state_q)
                IDLE, DONE: if (start) begin
                    state_q   <= RUN;
                    playing_q <= 1'b1;
                    done_q    <= 1'b0;
                end
                RUN: if (xfer && chart_last) state_q <= DRAIN;
                DRAIN: if (boundary && (drain_q == DR_W'(NUM_ROWS - 1))) begin
                    state_q   <= DONE;
                    playing_q <= 1'b0;
                    done_q    <= 1'b1;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            phase_q <= '0;
            drain_q <= '0;
            score_q <= '0;
            combo_q <= '0;
            hit_q   <= '0;
            miss_q  <= '0;
        end else begin
            phase_q <= phase_d;
            drain_q <= drain_d;
            score_q <= score_d;
            combo_q <= combo_d;
            hit_q   <= hit_c;
            miss_q  <= miss_c;
        end
    end

    assign note_grid    = rows;
    assign scroll_phase = phase_q;
    assign hit          = hit_q;
    assign miss         = miss_q;
    assign score        = score_q;
    assign combo        = combo_q;
    assign playing      = playing_q;
    assign done         = done_q;
endmodule

// File: tb/tb_note_scheduler.sv
// Directed bench for note_scheduler with a hit/miss event scoreboard.
module tb_note_scheduler;
    localparam int NL = 8, NR = 4, TPS = 2, SW = 16, NSAT = 280;

    logic                 Clk = 1'b0, Reset = 1'b1, start = 1'b0, frame_tick = 1'b0;
    logic                 chart_valid = 1'b0, chart_last = 1'b0;
    logic [NL-1:0]        keyTrack = '0, chart_data = '0;
    logic                 chart_ready, playing, done;
    logic [NL*NR-1:0]     note_grid;
    logic [$clog2(TPS)-1:0] scroll_phase;
    logic [NL-1:0]        hit, miss;
    logic [SW-1:0]        score;
    logic [7:0]           combo;

    typedef struct {
        logic [7:0]  hit;
        logic [7:0]  miss;
        logic [15:0] score;
        logic [7:0]  combo;
    } ev_t;

    ev_t sb[$];
    int  n_assert = 0, n_fail = 0;
    int  exp_score = 0, exp_combo = 0;

    note_scheduler #(.NUM_LANES(NL), .NUM_ROWS(NR), .TICKS_PER_STEP(TPS), .SCORE_W(SW)) dut (
        .Clk(Clk), .Reset(Reset), .start(start), .frame_tick(frame_tick), .keyTrack(keyTrack),
        .chart_valid(chart_valid), .chart_data(chart_data), .chart_last(chart_last),
        .chart_ready(chart_ready), .note_grid(note_grid), .scroll_phase(scroll_phase),
        .hit(hit), .miss(miss), .score(score), .combo(combo), .playing(playing), .done(done)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        n_assert++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    task automatic cyc();
        @(negedge Clk);
    endtask

    task automatic expect_ev(input logic [7:0] h, input logic [7:0] m, input logic [15:0] s,
                             input logic [7:0] c);
        ev_t e;
        e.hit = h; e.miss = m; e.score = s; e.combo = c;
        sb.push_back(e);
    endtask

    task automatic expect_hits(input logic [7:0] mask);
        int n;
        n = $countones(mask);
        exp_score = exp_score + n * (1 + (exp_combo >> 3));
        if (exp_score > 65535) exp_score = 65535;
        exp_combo = exp_combo + n;
        if (exp_combo > 255) exp_combo = 255;
        expect_ev(mask, 8'h00, 16'(exp_score), 8'(exp_combo));
    endtask

    // Two frame ticks: the second is the step boundary; keys may rise on the boundary cycle.
    task automatic adv(input logic [7:0] d, input logic v, input logic last,
                       input logic [7:0] bkeys, input logic exp_rdy);
        frame_tick = 1'b1; chart_valid = v; chart_data = d; chart_last = last; keyTrack = '0;
        #1 chk("ready_mid_step", 64'(chart_ready), 64'(0));
        cyc();
        keyTrack = bkeys;
        #1 chk("ready_boundary", 64'(chart_ready), 64'(exp_rdy));
        cyc();
        frame_tick = 1'b0; chart_valid = 1'b0; chart_last = 1'b0; keyTrack = '0;
        cyc();
    endtask

    task automatic press(input logic [7:0] keys);
        keyTrack = keys;
        cyc();
        keyTrack = '0;
        cyc();
    endtask

    task automatic start_pulse();
        start = 1'b1;
        cyc();
        start = 1'b0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_grid"},  64'(note_grid), 64'(0));
        chk({tag, "_phase"}, 64'(scroll_phase), 64'(0));
        chk({tag, "_hitmiss"}, 64'({hit, miss}), 64'(0));
        chk({tag, "_score"}, 64'(score), 64'(0));
        chk({tag, "_combo"}, 64'(combo), 64'(0));
        chk({tag, "_flags"}, 64'({playing, done}), 64'(0));
        chk({tag, "_ready"}, 64'(chart_ready), 64'(0));
    endtask

    always @(negedge Clk) begin
        if (!Reset && ((|{hit, miss}) === 1'b1)) begin
            if (sb.size() == 0) begin
                chk("unexpected_event", 64'({hit, miss}), 64'(0));
            end else begin
                ev_t e;
                e = sb.pop_front();
                chk("ev_hit",   64'(hit),   64'(e.hit));
                chk("ev_miss",  64'(miss),  64'(e.miss));
                chk("ev_score", 64'(score), 64'(e.score));
                chk("ev_combo", 64'(combo), 64'(e.combo));
            end
        end
    end

    initial begin
        #200000;
        n_fail++;
        $display("FAIL watchdog: observed timeout expected finish");
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $fatal(1, "watchdog");
    end

    initial begin
        // reset state, with inputs active to show nothing leaks through
        frame_tick = 1'b1; chart_valid = 1'b1; chart_data = 8'hFF;
        cyc(); cyc();
        #1 chk_all_zero("reset");
        frame_tick = 1'b0; chart_valid = 1'b0; chart_data = '0;
        Reset = 1'b0;
        cyc();
        start_pulse();
        chk("start_playing", 64'({playing, done}), 64'(2'b10));

        // basic flow
        adv(8'h01, 1'b1, 1'b0, 8'h00, 1'b1);
        chk("basic_grid1", 64'(note_grid), 64'(32'h0000_0001));
        adv(8'h80, 1'b1, 1'b1, 8'h00, 1'b1);
        chk("basic_grid2", 64'(note_grid), 64'(32'h1000_0002));
        adv(8'h00, 1'b0, 1'b0, 8'h00, 1'b0);
        chk("drain_grid1", 64'(note_grid), 64'(32'h2000_0004));
        adv(8'h00, 1'b0, 1'b0, 8'h00, 1'b0);
        chk("lane0_row3", 64'(note_grid), 64'(32'h4000_0008));
        expect_ev(8'h00, 8'h01, 16'd0, 8'd0);
        adv(8'h00, 1'b0, 1'b0, 8'h00, 1'b0);
        chk("drain_grid3", 64'(note_grid), 64'(32'h8000_0000));
        chk("drain_flags", 64'({playing, done}), 64'(2'b10));
        expect_ev(8'h00, 8'h80, 16'd0, 8'd0);
        adv(8'h00, 1'b0, 1'b0, 8'h00, 1'b0);
        chk("done_grid", 64'(note_grid), 64'(0));
        chk("done_flags", 64'({playing, done}), 64'(2'b01));

        // single hit
        start_pulse();
        chk("restart_flags", 64'({playing, done}), 64'(2'b10));
        adv(8'h01, 1'b1, 1'b0, 8'h00, 1'b1);
        repeat (3) adv(8'h00, 1'b1, 1'b0, 8'h00, 1'b1);
        chk("hit_setup_grid", 64'(note_grid), 64'(32'h0000_0008));
        expect_ev(8'h01, 8'h00, 16'd1, 8'd1);
        press(8'h01);
        chk("hit_cleared", 64'(note_grid), 64'(0));
        chk("hit_score", 64'(score), 64'(1));
        chk("hit_combo", 64'(combo), 64'(1));
        adv(8'h00, 1'b1, 1'b0, 8'h00, 1'b1);

        // combo build to 9, then an unhit lane-2 note
        for (int i = 0; i < 12; i++) begin
            logic [7:0] d;
            d = (i < 7) ? 8'h01 : ((i == 7) ? 8'h05 : 8'h00);
            if (i == 11) expect_ev(8'h00, 8'h04, 16'd10, 8'd0);
            adv(d, 1'b1, 1'b0, 8'h00, 1'b1);
            if (i >= 3 && i <= 10) begin
                expect_ev(8'h01, 8'h00, (i == 10) ? 16'd10 : 16'(i - 1), 8'(i - 1));
                press(8'h01);
            end
        end
        chk("miss_combo", 64'(combo), 64'(0));
        chk("miss_score", 64'(score), 64'(10));

        // start during RUN is ignored
        start_pulse();
        chk("start_ignored_score", 64'(score), 64'(10));
        chk("start_ignored_flags", 64'({playing, done}), 64'(2'b10));

        // hit on the boundary cycle, then two hits with a miss
        adv(8'h02, 1'b1, 1'b0, 8'h00, 1'b1);
        adv(8'h38, 1'b1, 1'b0, 8'h00, 1'b1);
        adv(8'h00, 1'b1, 1'b0, 8'h00, 1'b1);
        adv(8'h00, 1'b1, 1'b0, 8'h00, 1'b1);
        chk("simul_setup", 64'(note_grid), 64'(32'h0044_4080));
        expect_ev(8'h02, 8'h00, 16'd11, 8'd1);
        adv(8'h00, 1'b1, 1'b0, 8'h02, 1'b1);
        chk("simul_shift", 64'(note_grid), 64'(32'h0088_8000));
        expect_ev(8'h18, 8'h20, 16'd13, 8'd0);
        adv(8'h00, 1'b1, 1'b0, 8'h18, 1'b1);
        chk("simul_grid", 64'(note_grid), 64'(0));
        chk("simul_score", 64'(score), 64'(13));

        // underrun then late data
        adv(8'h40, 1'b0, 1'b0, 8'h00, 1'b1);
        chk("underrun_grid", 64'(note_grid), 64'(0));
        adv(8'h40, 1'b1, 1'b0, 8'h00, 1'b1);
        chk("late_data_grid", 64'(note_grid), 64'(32'h0100_0000));

        // asynchronous reset mid-song, mid-step
        frame_tick = 1'b1; chart_valid = 1'b1; chart_data = 8'hFF;
        cyc();
        chk("pre_reset_phase", 64'(scroll_phase), 64'(1));
        chk("pre_reset_ready", 64'(chart_ready), 64'(1));
        #2 Reset = 1'b1;
        #1 chk_all_zero("midreset");
        frame_tick = 1'b0; chart_valid = 1'b0; chart_data = '0;
        cyc();
        Reset = 1'b0;
        cyc();
        start_pulse();
        chk("clean_restart_grid", 64'(note_grid), 64'(0));
        chk("clean_restart_score", 64'(score), 64'(0));

        // saturation: stream full rows and hit every one
        exp_score = 0; exp_combo = 0;
        for (int s = 0; s < NSAT + 3; s++) begin
            adv((s < NSAT) ? 8'hFF : 8'h00, 1'b1, 1'b0, 8'h00, 1'b1);
            if (s == 0) chk("restart_first_row", 64'(note_grid), 64'(32'h1111_1111));
            if (s >= 3) begin
                expect_hits(8'hFF);
                press(8'hFF);
            end
        end
        chk("sat_score", 64'(score), 64'(16'hFFFF));
        chk("sat_combo", 64'(combo), 64'(8'hFF));
        chk("sat_grid", 64'(note_grid), 64'(0));
        cyc();
        chk("scoreboard_drained", 64'(sb.size()), 64'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
